// File: rtl/div_sequencer.sv
// Multi-cycle integer divider sequencer (RISC-V M-extension DIV/DIVU/REM/REMU).
// Restoring shift-subtract on unsigned magnitudes, one quotient bit per cycle.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow skip CALC
// and complete one cycle after start.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivStart,
  input  logic [2:0]       DivFunct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             DivBusy,
  output logic             DivDone,
  output logic [WIDTH-1:0] DivResult
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic [WIDTH-1:0] dvd_orig;  // original dividend, returned as remainder on divide-by-zero
  logic             sel_rem;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             start_ok;
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] res_fin;

  assign DivBusy = (state == CALC);
  assign DivDone = (state == DONE);

  // Decode the start request and derive operand magnitudes.
  always_comb begin
    start_ok  = DivStart & ~Flush & DivFunct3[2];
    signed_op = ~DivFunct3[0];
    a_neg     = signed_op & SrcA[WIDTH-1];
    b_neg     = signed_op & SrcB[WIDTH-1];
    b_zero    = (SrcB == '0);
    a_mag     = a_neg ? -SrcA : SrcA;
    b_mag     = b_neg ? -SrcB : SrcB;
  end

`ifdef DIV_FAST_PATH_EN
  logic             ovf;
  logic [WIDTH-1:0] res_fast;

  // Special-case results available directly from the operands at start.
  always_comb begin
    ovf      = signed_op & (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcB == '1);
    res_fast = '0;
    if (b_zero) res_fast = DivFunct3[1] ? SrcA : '1;
    else        res_fast = DivFunct3[1] ? '0 : SrcA;
  end
`endif

  // One restoring step plus final sign fix-up of the result.
  // Invariant rem < dvs keeps the trial difference below 2^WIDTH, so bit WIDTH is the borrow.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
    q_fin = neg_q ? -quo_nx : quo_nx;
    r_fin = neg_r ? -rem_nx : rem_nx;
    if (dz) res_fin = sel_rem ? dvd_orig : '1;
    else    res_fin = sel_rem ? r_fin : q_fin;
  end

  // Sequencer state, datapath registers and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      dvd_orig  <= '0;
      sel_rem   <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      DivResult <= '0;
    end else if (Flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            quo      <= a_mag;
            rem      <= '0;
            dvs      <= b_mag;
            dvd_orig <= SrcA;
            sel_rem  <= DivFunct3[1];
            neg_q    <= signed_op & (a_neg ^ b_neg) & ~b_zero;
            neg_r    <= a_neg;
            dz       <= b_zero;
`ifdef DIV_FAST_PATH_EN
            if (b_zero || ovf) begin
              state     <= DONE;
              cnt       <= '0;
              DivResult <= res_fast;
            end else begin
              state <= CALC;
              cnt   <= CW'(WIDTH);
            end
`else
            state <= CALC;
            cnt   <= CW'(WIDTH);
`endif
          end
        end
        CALC: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            DivResult <= res_fin;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
